// File: rtl/vwrite_buf.sv
// Posted-write FIFO between the vwrite databus master and the downstream port.
// Define VWRITE_BUF_MERGE_EN to coalesce a write into the tail entry on an address match.
`ifndef IO_ADDR_W
`define IO_ADDR_W 32
`endif

module vwrite_buf #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = `IO_ADDR_W,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [ADDR_W-1:0]     s_addr,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  output logic [DATA_W-1:0]     s_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_W-1:0]     m_addr,
  output logic [DATA_W-1:0]     m_wdata,
  output logic [DATA_W/8-1:0]   m_wstrb,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  idle
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];
  logic [STRB_W-1:0] strbMem [DEPTH];

  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [DEPTH_LOG2:0]   count;
  logic                  full, mergeHit, accept, push, pop;

  assign full    = (count == FULL_LVL);
  assign s_ready = !full || mergeHit;
  assign accept  = s_valid && s_ready;
  assign push    = accept && !mergeHit;
  assign pop     = m_valid && m_ready;

  assign s_rdata = '0;
  assign m_valid = (count != '0);
  assign idle    = (count == '0);
  assign level   = count;
  assign m_addr  = addrMem[rdPtr];
  assign m_wdata = dataMem[rdPtr];
  assign m_wstrb = strbMem[rdPtr];

`ifdef VWRITE_BUF_MERGE_EN
  logic [DEPTH_LOG2-1:0] tailPtr;
  logic [DATA_W-1:0]     mergedData;

  assign tailPtr = wrPtr - 1'b1;
  // level >= 2 keeps the head (possibly mid-handshake) out of reach of a merge
  assign mergeHit = (count[DEPTH_LOG2:1] != '0) && (addrMem[tailPtr] == s_addr);

  always_comb begin
    mergedData = dataMem[tailPtr];
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (s_wstrb[i]) mergedData[i*8 +: 8] = s_wdata[i*8 +: 8];
    end
  end
`else
  assign mergeHit = 1'b0;
`endif

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr] <= s_addr;
      dataMem[wrPtr] <= s_wdata;
      strbMem[wrPtr] <= s_wstrb;
    end
`ifdef VWRITE_BUF_MERGE_EN
    else if (accept && mergeHit) begin
      dataMem[tailPtr] <= mergedData;
      strbMem[tailPtr] <= strbMem[tailPtr] | s_wstrb;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_vwrite_buf.sv
// Directed bench for vwrite_buf with a queue scoreboard of expected drained writes.
// Expectations follow VWRITE_BUF_MERGE_EN when it is defined for the build.
module tb_vwrite_buf;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_addr = '0;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic [31:0] s_rdata;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [2:0]  level;
  logic        idle;

  ent_t sb[$];
  int   checkCount = 0;
  int   passCount  = 0;
  bit   mergeModel;
  bit   acc;

  vwrite_buf #(.DATA_W(32), .ADDR_W(32), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .level(level), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called just after inputs are driven on a falling edge; predicts the next rising edge.
  task automatic tick(output bit accepted);
    bit   hit, popNow;
    ent_t e;
    #1;
    hit = mergeModel && (sb.size() >= 2) && (s_addr === sb[$].a);
    check("level", 64'(level), 64'(sb.size()));
    check("m_valid", 64'(m_valid), 64'(sb.size() != 0));
    check("idle", 64'(idle), 64'(sb.size() == 0));
    check("s_ready", 64'(s_ready), 64'((sb.size() < 4) || hit));
    accepted = s_valid && s_ready;
    popNow   = m_valid && m_ready;
    if (popNow && sb.size() != 0) begin
      e = sb.pop_front();
      check("m_addr", 64'(m_addr), 64'(e.a));
      check("m_wdata", 64'(m_wdata), 64'(e.d));
      check("m_wstrb", 64'(m_wstrb), 64'(e.s));
    end
    if (accepted) begin
      if (hit) begin
        e = sb[$];
        for (int i = 0; i < 4; i++)
          if (s_wstrb[i]) e.d[i*8 +: 8] = s_wdata[i*8 +: 8];
        e.s = e.s | s_wstrb;
        sb[$] = e;
      end else begin
        sb.push_back('{a: s_addr, d: s_wdata, s: s_wstrb});
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    s_valid = 1'b1;
    s_addr  = a;
    s_wdata = d;
    s_wstrb = s;
  endtask

  task automatic writeWait(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit got;
    got = 1'b0;
    drive(a, d, s);
    for (int i = 0; i < 16 && !got; i++) tick(got);
    if (!got) check("write_timeout", 64'd0, 64'd1);
    s_valid = 1'b0;
  endtask

  task automatic drainAll();
    bit dummy;
    m_ready = 1'b1;
    for (int i = 0; i < 32 && sb.size() != 0; i++) tick(dummy);
    if (sb.size() != 0) check("drain_timeout", 64'(sb.size()), 64'd0);
    m_ready = 1'b0;
    tick(dummy);
  endtask

  initial begin
`ifdef VWRITE_BUF_MERGE_EN
    mergeModel = 1'b1;
`else
    mergeModel = 1'b0;
`endif
    #2;
    check("rst_level", 64'(level), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("s_rdata", 64'(s_rdata), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // single write, one-cycle latency, then drain
    writeWait(32'h100, 32'hDEADBEEF, 4'hF);
    check("lat_m_valid", 64'(m_valid), 64'd1);
    check("lat_m_addr", 64'(m_addr), 64'h100);
    drainAll();

    // fill, stall on full, release with one pop
    writeWait(32'h0, 32'hA0, 4'hF);
    writeWait(32'h4, 32'hA4, 4'hF);
    writeWait(32'h8, 32'hA8, 4'hF);
    writeWait(32'hC, 32'hAC, 4'hF);
    drive(32'h10, 32'hB0, 4'hF);
    #1;
    check("full_level", 64'(level), 64'd4);
    check("full_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick(acc);
    check("stall_no_accept", 64'(sb.size()), 64'd4);
    m_ready = 1'b1;
    tick(acc);
    check("full_no_passthru", 64'(acc), 64'd0);
    m_ready = 1'b0;
    tick(acc);
    check("fifth_accepted", 64'(acc), 64'd1);
    s_valid = 1'b0;
    drainAll();

    // simultaneous push and pop at level 2
    writeWait(32'h40, 32'h40, 4'hF);
    writeWait(32'h44, 32'h44, 4'h3);
    drive(32'h48, 32'h48, 4'hC);
    m_ready = 1'b1;
    tick(acc);
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1;
    check("pushpop_level", 64'(level), 64'd2);
    @(negedge clk);
    drainAll();

    // asynchronous reset mid-operation at level 3
    writeWait(32'h80, 32'h80, 4'hF);
    writeWait(32'h84, 32'h84, 4'hF);
    writeWait(32'h88, 32'h88, 4'hF);
    #3;
    rst = 1'b0;
    #1;
    check("arst_m_valid", 64'(m_valid), 64'd0);
    check("arst_level", 64'(level), 64'd0);
    check("arst_idle", 64'(idle), 64'd1);
    check("arst_s_ready", 64'(s_ready), 64'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    writeWait(32'h90, 32'h12345678, 4'h5);
    drainAll();

    // tail merge (or three separate entries without merging)
    writeWait(32'h20, 32'h11111111, 4'hF);
    writeWait(32'h24, 32'h22222222, 4'hF);
    writeWait(32'h24, 32'h000000AB, 4'h1);
    #1;
`ifdef VWRITE_BUF_MERGE_EN
    check("merge_level", 64'(level), 64'd2);
`else
    check("nomerge_level", 64'(level), 64'd3);
`endif
    @(negedge clk);
    drainAll();

    // a single-entry queue never merges into the head
    writeWait(32'h60, 32'hAAAA5555, 4'hF);
    writeWait(32'h60, 32'h00000011, 4'h1);
    #1;
    check("head_no_merge", 64'(level), 64'd2);
    @(negedge clk);
    drainAll();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vwrite_buf.md
VWRITE_BUF -- requirements
Module: vwrite_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_W, default `IO_ADDR_W, external address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 2, giving a queue depth of 2**DEPTH_LOG2 entries.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port s_valid, input, 1 bit: upstream write request from the vwrite databus master.
REQ-007 SHALL have port s_ready, output, 1 bit: upstream accept; a write is accepted in any cycle where s_valid and s_ready are both high.
REQ-008 SHALL have ports s_addr, s_wdata and s_wstrb, all inputs, of widths ADDR_W, DATA_W and DATA_W/8: the upstream write payload.
REQ-009 SHALL have port s_rdata, output, DATA_W bits: tied to 0, because the write path does not read.
REQ-010 SHALL have port m_valid, output, 1 bit: downstream write request.
REQ-011 SHALL have port m_ready, input, 1 bit: downstream accept.
REQ-012 SHALL have ports m_addr, m_wdata and m_wstrb, all outputs, of widths ADDR_W, DATA_W and DATA_W/8: the payload of the head entry.
REQ-013 SHALL have port level, output, DEPTH_LOG2+1 bits: the number of occupied entries.
REQ-014 SHALL have port idle, output, 1 bit: high when level is 0.

Function
REQ-015 SHALL be a circular FIFO with write pointer, read pointer and occupancy counter; pointers wrap modulo 2**DEPTH_LOG2.
REQ-016 s_ready SHALL be combinational: high when level < 2**DEPTH_LOG2, or when a merge hit occurs (see REQ-027).
REQ-017 On acceptance without a merge, SHALL store {s_addr, s_wdata, s_wstrb} at the write pointer and increment the write pointer.
REQ-018 m_valid SHALL equal (level != 0), and m_addr, m_wdata and m_wstrb SHALL present the entry at the read pointer.
REQ-019 On m_valid and m_ready both high, SHALL increment the read pointer; the next entry appears on the following cycle.
REQ-020 A push and a pop in the same cycle SHALL leave level unchanged.
REQ-021 Full case: with no merge hit, s_ready SHALL be 0 even if m_ready is 1; there is no same-cycle pass-through.
REQ-022 Empty case: m_valid SHALL be 0 and the m_* payload is don't-care.
REQ-023 Latency from upstream acceptance to m_valid SHALL be exactly 1 cycle when the queue was empty.
REQ-024 Writes SHALL leave in acceptance order; none SHALL be dropped or duplicated.
REQ-025 level SHALL never exceed 2**DEPTH_LOG2 and never underflow.

Reset
REQ-026 Asserting rst low SHALL asynchronously clear the pointers and level, forcing m_valid=0, level=0, idle=1 and s_ready=1 (combinational on the cleared state). Reset mid-operation SHALL discard every queued entry, including the head currently being presented. Storage contents need not be reset.

Configuration
REQ-027 With macro VWRITE_BUF_MERGE_EN defined, a merge hit SHALL occur when level >= 2 and s_addr equals the tail entry's (write pointer - 1) address.
- On an accepted hit: tail bytes whose s_wstrb bit is 1 SHALL be replaced, tail wstrb SHALL be OR-ed with s_wstrb, and pointers and level SHALL be unchanged.
- The head entry SHALL never be merged.
REQ-028 Without VWRITE_BUF_MERGE_EN, no merge logic SHALL exist, and every accepted write SHALL occupy a new entry.

Verification
REQ-029 Reset then single write: addr 0x100, data 0xDEADBEEF, strb 0xF -> m_valid rises 1 cycle later carrying that payload; with m_ready=1 it drains and idle returns to 1.
REQ-030 Fill with m_ready=0: 4 writes to addr 0x0, 0x4, 0x8, 0xC -> level=4 and s_ready=0; a 5th write to 0x10 stalls until one m_ready pulse, then is accepted; drained order is 0x0, 0x4, 0x8, 0xC, 0x10.
REQ-031 Simultaneous push and pop at level=2 -> level stays 2 and order is preserved.
REQ-032 Reset asserted at level=3 -> m_valid=0 and level=0 immediately (asynchronously); after release, only new writes appear.
REQ-033 With VWRITE_BUF_MERGE_EN, m_ready=0: write 0x20/0x11111111/strb 0xF, write 0x24/0x22222222/0xF, then write 0x24/0x000000AB/0x1 -> level=2, and the tail drains as 0x222222AB with strb 0xF.
REQ-034 Without VWRITE_BUF_MERGE_EN, the same stimulus as REQ-033 -> level=3, and three writes drain in order.
